dmem_mmio: RTL and testbench
============================

DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, RAM size in 32-bit words (power of two).
REQ-002 SHALL have parameter MMIO_BASE, default 32'hFFFF_0000, base of the timer register window (64-byte aligned).
REQ-003 SHALL have parameter PRESCALE, default 1, clk cycles per mtime increment (>=1).
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port clr, input, 1, synchronous active-high reset.
REQ-006 SHALL have port A, input, 32, byte address from the memory stage (ALUResultM).
REQ-007 SHALL have port WD, input, 32, store data (WriteDataM), lanes already aligned.
REQ-008 SHALL have port WE, input, 1, store strobe (MemWriteM).
REQ-009 SHALL have port byteEnable, input, 4, per-lane write enable; bit i covers WD[8i+7:8i].
REQ-010 SHALL have port RD, output, 32, load data (to RD_data).
REQ-011 SHALL have port irq, output, 1, timer interrupt pending.

Function
REQ-012 SHALL decode RAM when A < DEPTH_WORDS*4, MMIO when A[31:6] == MMIO_BASE[31:6], else unmapped.
REQ-013 SHALL return RD combinationally in the same cycle as A: full word at index A[log2(DEPTH_WORDS)+1:2]; A[1:0] ignored.
REQ-014 SHALL write RAM at the rising edge when WE=1, updating only lanes with byteEnable=1; other lanes unchanged.
REQ-015 SHALL return RD=0 and ignore writes for unmapped addresses.
REQ-016 SHALL map MMIO offsets: 0x00 mtime[31:0], 0x04 mtime[63:32], 0x08 mtimecmp[31:0], 0x0C mtimecmp[63:32], 0x10 ctrl; other offsets read 0, writes ignored.
REQ-017 SHALL define ctrl bit0 = EN (R/W), bit1 = PEND (read; write 1 clears), bits[31:2] read 0.
REQ-018 SHALL honour byteEnable on every MMIO register write.
REQ-019 SHALL keep a prescale counter counting 0..PRESCALE-1 while EN=1, wrapping to 0; mtime increments by 1 on the cycle the counter wraps; counter and mtime hold while EN=0.
REQ-020 SHALL increment mtime as a full 64-bit value; 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
REQ-021 SHALL give a software write to either mtime half priority over the increment in the same cycle; the written value is loaded, the other half keeps its current value, no increment that cycle.
REQ-022 SHALL set PEND at the edge after any cycle where EN=1 and mtime >= mtimecmp (unsigned 64-bit); PEND stays set until cleared.
REQ-023 SHALL give set priority over W1C clear: if the compare holds in the clear cycle, PEND remains 1.
REQ-024 SHALL drive irq = PEND, registered, no combinational path from A/WD.
REQ-025 SHALL return register state as of before the edge when a read and write hit the same address in one cycle.

Reset
REQ-026 SHALL, on clr=1 at a rising edge, set mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, EN=0, PEND=0, prescale counter=0, irq=0.
REQ-027 SHALL NOT reset RAM contents; clr has priority over any store in the same cycle (MMIO write dropped, RAM write still performed).
REQ-028 SHALL keep RD a pure function of A and state during and after reset (RAM reads valid, MMIO reads reset values).

Configuration
REQ-029 SHALL compile the timer in only when macro DMEM_MMIO_TIMER_EN is defined.
REQ-030 SHALL, without DMEM_MMIO_TIMER_EN, treat the MMIO window as unmapped (RD=0, writes ignored), tie irq=0, and contain no timer registers; RAM behaviour is identical.

Verification
REQ-031 SHALL cover: store 32'hDEADBEEF to 0x10 with byteEnable=4'b0101 over prior 0x11223344 -> read 0x10 returns 32'h11AD33EF.
REQ-032 SHALL cover: load from 0x0100_0000 (unmapped) -> RD=0; store there leaves all RAM words unchanged.
REQ-033 SHALL cover: PRESCALE=4, write ctrl=1, run 40 cycles -> mtime_lo reads 10; clear EN -> value holds for 20 more cycles.
REQ-034 SHALL cover: mtime=0, mtimecmp=5, PRESCALE=1, EN=1 -> irq rises on the edge after mtime reaches 5; write ctrl=32'h3 -> irq stays 1; set mtimecmp_hi=1 then write ctrl=3 -> irq 0 next cycle.
REQ-035 SHALL cover: mtime=32'hFFFF_FFFF low half, EN=1 -> next increment gives mtime_hi=1, mtime_lo=0; same-cycle write mtime_lo=7 -> mtime_lo=7, no carry.
REQ-036 SHALL cover: clr asserted mid-count with PEND=1 -> next cycle irq=0, mtime=0, mtimecmp all ones, previously written RAM word still reads back.

Source files
------------

// File: rtl/dmem_mmio.sv
// Data memory with byte-lane stores plus an optional mtime/mtimecmp timer window.
// The timer is built only when DMEM_MMIO_TIMER_EN is defined; otherwise the window is unmapped.
module dmem_mmio #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
    parameter int unsigned PRESCALE    = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    input  logic        WE,
    input  logic [3:0]  byteEnable,
    output logic [31:0] RD,
    output logic        irq
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

    logic [31:0]   mem [DEPTH_WORDS];
    logic          ramSel;
    logic [AW-1:0] ramIdx;
    logic [31:0]   ramWord;
    logic          unusedIn;

    function automatic logic [31:0] laneMerge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [3:0] be);
        logic [31:0] res;
        res = old;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = wd[8*i +: 8];
        end
        return res;
    endfunction

    assign ramSel  = ({1'b0, A} < RAM_BYTES);
    assign ramIdx  = A[AW+1:2];
    assign ramWord = mem[ramIdx];

    // RAM is never cleared and still accepts stores while clr is asserted
    always_ff @(posedge clk) begin
        if (WE && ramSel) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (byteEnable[i]) mem[ramIdx][8*i +: 8] <= WD[8*i +: 8];
            end
        end
    end

`ifdef DMEM_MMIO_TIMER_EN
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PSC_MAX = PW'(PRESCALE - 1);

    logic [63:0]   mtime;
    logic [63:0]   mtimecmp;
    logic          en;
    logic          pend;
    logic [PW-1:0] pscCnt;
    logic          mmioSel;
    logic          wrMmio;
    logic          tick;
    logic          cmpHit;
    logic          ctrlW1c;
    logic [3:0]    regIdx;
    logic [31:0]   regRd;

    assign mmioSel  = !ramSel && (A[31:6] == MMIO_BASE[31:6]);
    assign regIdx   = A[5:2];
    assign wrMmio   = WE && mmioSel;
    assign tick     = en && (pscCnt == PSC_MAX);
    assign cmpHit   = en && (mtime >= mtimecmp);
    assign ctrlW1c  = wrMmio && (regIdx == 4'd4) && byteEnable[0] && WD[1];
    assign unusedIn = ^A[1:0];

    always_ff @(posedge clk) begin
        if (clr) begin
            mtime    <= '0;
            mtimecmp <= '1;
            en       <= 1'b0;
            pend     <= 1'b0;
            pscCnt   <= '0;
        end else begin
            if (en) pscCnt <= tick ? '0 : pscCnt + PW'(1);

            // a software write to either half wins over the increment
            if (wrMmio && regIdx == 4'd0)
                mtime <= {mtime[63:32], laneMerge(mtime[31:0], WD, byteEnable)};
            else if (wrMmio && regIdx == 4'd1)
                mtime <= {laneMerge(mtime[63:32], WD, byteEnable), mtime[31:0]};
            else if (tick)
                mtime <= mtime + 64'd1;

            if (wrMmio && regIdx == 4'd2)
                mtimecmp[31:0] <= laneMerge(mtimecmp[31:0], WD, byteEnable);
            if (wrMmio && regIdx == 4'd3)
                mtimecmp[63:32] <= laneMerge(mtimecmp[63:32], WD, byteEnable);

            if (wrMmio && regIdx == 4'd4 && byteEnable[0]) en <= WD[0];

            if (cmpHit)       pend <= 1'b1;
            else if (ctrlW1c) pend <= 1'b0;
        end
    end

    always_comb begin
        regRd = '0;
        case (regIdx)
            4'd0:    regRd = mtime[31:0];
            4'd1:    regRd = mtime[63:32];
            4'd2:    regRd = mtimecmp[31:0];
            4'd3:    regRd = mtimecmp[63:32];
            4'd4:    regRd = {30'b0, pend, en};
            default: regRd = '0;
        endcase
    end

    assign irq = pend;

    always_comb begin
        RD = '0;
        if (ramSel)       RD = ramWord;
        else if (mmioSel) RD = regRd;
    end
`else
    assign unusedIn = ^{A[1:0], clr};
    assign irq      = 1'b0;

    always_comb begin
        RD = '0;
        if (ramSel) RD = ramWord;
    end
`endif

endmodule

// File: tb/tb_dmem_mmio.sv
// Randomized and directed checks of dmem_mmio against a byte-level memory and timer model.
module tb_dmem_mmio;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned PSC   = 4;
    localparam logic [31:0] BASE  = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] WD = '0;
    logic        WE = 1'b0;
    logic [3:0]  byteEnable = '0;
    logic [31:0] RD;
    logic        irq;

    int errors = 0;
    int checks = 0;

    logic [31:0]  mRam [DEPTH];
    logic [3:0]   mKn  [DEPTH];
    logic [63:0]  mTime;
    logic [63:0]  mCmp;
    logic         mEn;
    logic         mPend;
    int unsigned  mPsc;

    dmem_mmio #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(BASE), .PRESCALE(PSC)) dut (
        .clk(clk), .clr(clr), .A(A), .WD(WD), .WE(WE),
        .byteEnable(byteEnable), .RD(RD), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic bit isRam(input logic [31:0] a);
        return a < DEPTH * 4;
    endfunction

    function automatic bit isMmio(input logic [31:0] a);
        return !isRam(a) && (a[31:6] == BASE[31:6]);
    endfunction

    task automatic modelReset();
        mTime = '0; mCmp = '1; mEn = 1'b0; mPend = 1'b0; mPsc = 0;
    endtask

    task automatic modelRead(input logic [31:0] a, output logic [31:0] exp, output logic [31:0] mask);
        int idx;
        exp = '0; mask = '1;
        if (isRam(a)) begin
            idx = int'(a >> 2);
            exp = mRam[idx];
            for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{mKn[idx][b]}};
        end
`ifdef DMEM_MMIO_TIMER_EN
        else if (isMmio(a)) begin
            case (a[5:0] & 6'h3C)
                6'h00: exp = mTime[31:0];
                6'h04: exp = mTime[63:32];
                6'h08: exp = mCmp[31:0];
                6'h0C: exp = mCmp[63:32];
                6'h10: exp = {30'b0, mPend, mEn};
                default: exp = '0;
            endcase
        end
`endif
    endtask

    task automatic modelEdge(input logic [31:0] a, input logic [31:0] wd, input logic we,
                             input logic [3:0] be, input logic c);
        int idx;
        bit wr, tick, hit;
        logic [5:0] off;
        if (we && isRam(a)) begin
            idx = int'(a >> 2);
            mRam[idx] = merge(mRam[idx], wd, be);
            mKn[idx]  = mKn[idx] | be;
        end
`ifdef DMEM_MMIO_TIMER_EN
        wr   = we && isMmio(a);
        off  = a[5:0] & 6'h3C;
        tick = mEn && (mPsc == PSC - 1);
        hit  = mEn && (mTime >= mCmp);
        if (c) modelReset();
        else begin
            if (mEn) mPsc = (mPsc + 1) % PSC;
            if (wr && off == 6'h00)      mTime[31:0]  = merge(mTime[31:0], wd, be);
            else if (wr && off == 6'h04) mTime[63:32] = merge(mTime[63:32], wd, be);
            else if (tick)               mTime = mTime + 1;
            if (wr && off == 6'h08) mCmp[31:0]  = merge(mCmp[31:0], wd, be);
            if (wr && off == 6'h0C) mCmp[63:32] = merge(mCmp[63:32], wd, be);
            if (wr && off == 6'h10 && be[0]) mEn = wd[0];
            if (hit) mPend = 1'b1;
            else if (wr && off == 6'h10 && be[0] && wd[1]) mPend = 1'b0;
        end
`else
        wr = 1'b0; off = '0; tick = 1'b0; hit = c;
`endif
    endtask

    // called in the low clock phase; checks outputs, then crosses one rising edge
    task automatic doCycle(input logic [31:0] a, input logic [31:0] wd, input logic we,
                           input logic [3:0] be, input logic c);
        logic [31:0] exp, mask;
        A = a; WD = wd; WE = we; byteEnable = be; clr = c;
        #1;
        modelRead(a, exp, mask);
        if (mask != 0) chk("rd", 64'(RD & mask), 64'(exp & mask));
        chk("irq", 64'(irq), 64'(mPend));
        @(posedge clk);
        modelEdge(a, wd, we, be, c);
        @(negedge clk);
        WE = 1'b0; clr = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        doCycle(a, d, 1'b1, 4'hF, 1'b0);
    endtask

    task automatic idle(input logic [31:0] a);
        doCycle(a, '0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic peek(input logic [31:0] a, input string tag, input logic [31:0] exp);
        A = a; WE = 1'b0; clr = 1'b0;
        #1;
        chk(tag, 64'(RD), 64'(exp));
    endtask

    task automatic pulseReset();
        doCycle(32'h0000_0200, '0, 1'b0, 4'h0, 1'b1);
    endtask

    initial begin
        logic [31:0] a, d;
        for (int i = 0; i < DEPTH; i++) begin
            mRam[i] = '0; mKn[i] = '0;
        end
        modelReset();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;

        // reset state
        chk("rstIrq", 64'(irq), 64'd0);
`ifdef DMEM_MMIO_TIMER_EN
        peek(BASE + 32'h00, "rstMtimeLo", 32'h0);
        peek(BASE + 32'h0C, "rstCmpHi", 32'hFFFF_FFFF);
        peek(BASE + 32'h10, "rstCtrl", 32'h0);
`else
        peek(BASE + 32'h0C, "noTimerRd", 32'h0);
`endif
        idle(32'h0);

        // partial-lane store
        wr(32'h10, 32'h1122_3344);
        doCycle(32'h10, 32'hDEAD_BEEF, 1'b1, 4'b0101, 1'b0);
        peek(32'h10, "laneMerge", 32'h11AD_33EF);
        peek(32'h13, "lowBitsIgnored", 32'h11AD_33EF);
        idle(32'h10);

        // fill RAM, store to unmapped address, read everything back
        for (int i = 0; i < DEPTH; i++) wr(32'(i * 4), $urandom);
        peek(32'h0100_0000, "unmappedRd", 32'h0);
        doCycle(32'h0100_0000, 32'hFFFF_FFFF, 1'b1, 4'hF, 1'b0);
        peek(32'(DEPTH * 4), "pastRamEnd", 32'h0);
        idle(32'h0);
        for (int i = 0; i < DEPTH; i++) idle(32'(i * 4));

`ifdef DMEM_MMIO_TIMER_EN
        // prescaled counting and hold while disabled
        pulseReset();
        wr(BASE + 32'h10, 32'h1);
        for (int i = 0; i < 40; i++) idle(BASE);
        peek(BASE, "prescaleCount", 32'd10);
        wr(BASE + 32'h10, 32'h0);
        for (int i = 0; i < 20; i++) idle(BASE);
        peek(BASE, "enHold", 32'd10);
        idle(BASE);

        // compare, sticky pend, set-over-clear, then clear
        pulseReset();
        wr(BASE + 32'h08, 32'd5);
        wr(BASE + 32'h0C, 32'd0);
        wr(BASE + 32'h10, 32'h1);
        for (int i = 0; i < 30; i++) idle(BASE + 32'h10);
        chk("irqRise", 64'(irq), 64'd1);
        wr(BASE + 32'h10, 32'h3);
        chk("setOverClear", 64'(irq), 64'd1);
        wr(BASE + 32'h0C, 32'd1);
        wr(BASE + 32'h10, 32'h3);
        chk("pendCleared", 64'(irq), 64'd0);
        idle(BASE);

        // 32-bit carry, then write priority over the carrying increment
        pulseReset();
        wr(BASE + 32'h00, 32'hFFFF_FFFF);
        wr(BASE + 32'h10, 32'h1);
        for (int i = 0; i < PSC; i++) idle(BASE);
        peek(BASE + 32'h04, "carryHi", 32'd1);
        peek(BASE + 32'h00, "carryLo", 32'd0);
        idle(BASE);
        pulseReset();
        wr(BASE + 32'h00, 32'hFFFF_FFFF);
        wr(BASE + 32'h10, 32'h1);
        for (int i = 0; i < PSC - 1; i++) idle(BASE);
        wr(BASE + 32'h00, 32'd7);
        peek(BASE + 32'h00, "wrPrioLo", 32'd7);
        peek(BASE + 32'h04, "wrPrioHi", 32'd0);
        idle(BASE);

        // reset mid-count with pend set
        pulseReset();
        wr(32'h8, 32'hCAFE_F00D);
        wr(BASE + 32'h08, 32'd0);
        wr(BASE + 32'h0C, 32'd0);
        wr(BASE + 32'h10, 32'h1);
        for (int i = 0; i < 6; i++) idle(BASE);
        chk("pendBeforeClr", 64'(irq), 64'd1);
        doCycle(BASE + 32'h08, 32'h0, 1'b1, 4'hF, 1'b1);
        chk("clrIrq", 64'(irq), 64'd0);
        doCycle(32'hC, 32'h1234_5678, 1'b1, 4'hF, 1'b1);
        peek(BASE + 32'h00, "clrMtime", 32'h0);
        peek(BASE + 32'h08, "clrCmpLo", 32'hFFFF_FFFF);
        peek(BASE + 32'h0C, "clrCmpHi", 32'hFFFF_FFFF);
        idle(32'h0);
        peek(32'h8, "ramSurvivesClr", 32'hCAFE_F00D);
        peek(32'hC, "ramWrInClr", 32'h1234_5678);
        idle(32'h0);
`else
        wr(BASE + 32'h10, 32'h1);
        wr(BASE + 32'h00, 32'h55);
        peek(BASE + 32'h00, "noTimerWr", 32'h0);
        chk("noTimerIrq", 64'(irq), 64'd0);
        idle(32'h0);
`endif

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            case ($urandom_range(7, 0))
                0, 1, 2, 3: a = 32'($urandom_range(DEPTH * 4 - 1, 0));
                4, 5:       a = BASE + 32'($urandom_range(63, 0));
                6:          a = {4'h1, 28'($urandom)};
                default:    a = 32'(DEPTH * 4 - 4 + $urandom_range(7, 0));
            endcase
            d = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(40, 0)) : $urandom;
            doCycle(a, d, 1'($urandom_range(1, 0)), 4'($urandom),
                    $urandom_range(127, 0) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
